// File: rtl/stopwatch_timer_dp_if.sv
// Control/status bundle between the button/control unit and the stopwatch datapath.
// The master side drives the command pulses and presets; the slave side returns time and lap state.
interface stopwatch_timer_dp_if;
  logic       run_stop;
  logic       clear;
  logic       load;
  logic [5:0] load_min;
  logic [5:0] load_sec;
  logic       dir;
  logic       lap;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [6:0] lap_msec;
  logic [5:0] lap_sec;
  logic [5:0] lap_min;
  logic [4:0] lap_hour;
  logic       lap_valid;
  logic       running;
  logic       done;

  modport master (
    output run_stop, clear, load, load_min, load_sec, dir, lap,
    input  msec, sec, min, hour, lap_msec, lap_sec, lap_min, lap_hour,
    input  lap_valid, running, done
  );

  modport slave (
    input  run_stop, clear, load, load_min, load_sec, dir, lap,
    output msec, sec, min, hour, lap_msec, lap_sec, lap_min, lap_hour,
    output lap_valid, running, done
  );
endinterface

// File: rtl/stopwatch_timer_dp.sv
// Up/down stopwatch datapath: centisecond prescaler, msec/sec/min/hour chain with
// single-edge carry/borrow, preset load, lap capture and a countdown-done pulse.
module stopwatch_timer_dp #(
  parameter int TICK_DIV = 1_000_000,
  parameter int HOUR_MOD = 24
) (
  input logic                 clk,
  input logic                 reset,
  stopwatch_timer_dp_if.slave bus
);
  localparam int              PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0]   PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [4:0]      HOUR_MAX = 5'(HOUR_MOD - 1);

  typedef enum logic [1:0] {STOP, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic          done_nxt;
  logic [PW-1:0] presc;
  logic          dir_reg, running, done, lap_valid;
  logic [6:0]    msec, lap_msec;
  logic [5:0]    sec, min, lap_sec, lap_min;
  logic [4:0]    hour, lap_hour;

  logic          tick, c_sec, c_min, c_hour, b_sec, b_min, b_hour, zero_now, zero_dn;
  logic [6:0]    msec_up, msec_dn;
  logic [5:0]    sec_up, sec_dn, min_up, min_dn;
  logic [4:0]    hour_up, hour_dn;

  function automatic logic [5:0] sat59(input logic [5:0] v);
    return (v > 6'd59) ? 6'd59 : v;
  endfunction

  // All carries/borrows are decoded from the current value so every field moves on one edge.
  always_comb begin
    tick    = (state == RUN) && (presc == PRE_MAX);
    c_sec   = (msec == 7'd99);
    c_min   = c_sec && (sec == 6'd59);
    c_hour  = c_min && (min == 6'd59);
    msec_up = c_sec ? 7'd0 : msec + 7'd1;
    sec_up  = c_sec ? ((sec == 6'd59) ? 6'd0 : sec + 6'd1) : sec;
    min_up  = c_min ? ((min == 6'd59) ? 6'd0 : min + 6'd1) : min;
    hour_up = c_hour ? ((hour == HOUR_MAX) ? 5'd0 : hour + 5'd1) : hour;
    b_sec   = (msec == 7'd0);
    b_min   = b_sec && (sec == 6'd0);
    b_hour  = b_min && (min == 6'd0);
    msec_dn = b_sec ? 7'd99 : msec - 7'd1;
    sec_dn  = b_sec ? ((sec == 6'd0) ? 6'd59 : sec - 6'd1) : sec;
    min_dn  = b_min ? ((min == 6'd0) ? 6'd59 : min - 6'd1) : min;
    hour_dn = b_hour ? ((hour == 5'd0) ? HOUR_MAX : hour - 5'd1) : hour;
    zero_now = (msec == 7'd0) && (sec == 6'd0) && (min == 6'd0) && (hour == 5'd0);
    zero_dn  = (msec_dn == 7'd0) && (sec_dn == 6'd0) && (min_dn == 6'd0) && (hour_dn == 5'd0);
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= STOP;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    if (bus.clear || bus.load) begin
      state_nxt = STOP;
    end else begin
      case (state)
        STOP: begin
          if (bus.run_stop) begin
            if (dir_reg && zero_now) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = RUN;
            end
          end
        end
        RUN: begin
          if (tick && dir_reg && zero_dn) begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end else if (bus.run_stop) begin
            state_nxt = STOP;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = STOP;
      endcase
    end
  end

  // Prescaler only advances in RUN, so a pause keeps the partial tick.
  always_ff @(posedge clk) begin
    if (!reset) begin
      presc     <= '0;
      dir_reg   <= 1'b0;
      running   <= 1'b0;
      done      <= 1'b0;
      lap_valid <= 1'b0;
    end else begin
      running <= (state_nxt == RUN);
      done    <= done_nxt;
      if (state == STOP) dir_reg <= bus.dir;
      if (bus.clear || bus.load) begin
        presc     <= '0;
        lap_valid <= 1'b0;
      end else if (state == RUN) begin
        presc <= tick ? '0 : presc + PW'(1);
        if (bus.lap) lap_valid <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      msec     <= '0;
      sec      <= '0;
      min      <= '0;
      hour     <= '0;
      lap_msec <= '0;
      lap_sec  <= '0;
      lap_min  <= '0;
      lap_hour <= '0;
    end else begin
      if (bus.clear) begin
        msec <= '0;
        sec  <= '0;
        min  <= '0;
        hour <= '0;
      end else if (bus.load) begin
        msec <= '0;
        sec  <= sat59(bus.load_sec);
        min  <= sat59(bus.load_min);
        hour <= '0;
      end else if (tick) begin
        msec <= dir_reg ? msec_dn : msec_up;
        sec  <= dir_reg ? sec_dn  : sec_up;
        min  <= dir_reg ? min_dn  : min_up;
        hour <= dir_reg ? hour_dn : hour_up;
      end
      // Lap takes the value present before this edge's tick.
      if (!bus.clear && !bus.load && (state == RUN) && bus.lap) begin
        lap_msec <= msec;
        lap_sec  <= sec;
        lap_min  <= min;
        lap_hour <= hour;
      end
    end
  end

  assign bus.msec      = msec;
  assign bus.sec       = sec;
  assign bus.min       = min;
  assign bus.hour      = hour;
  assign bus.lap_msec  = lap_msec;
  assign bus.lap_sec   = lap_sec;
  assign bus.lap_min   = lap_min;
  assign bus.lap_hour  = lap_hour;
  assign bus.lap_valid = lap_valid;
  assign bus.running   = running;
  assign bus.done      = done;
endmodule
